// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer
// Generates the channel select for a downstream 1:8 demux. It sweeps the
// enabled channels of a latched mask in ascending order and holds each one
// for D = max(dwell,1) cycles. A run is either a single sweep or loops
// continuously. A start/busy/done handshake frames each run, and stop aborts it.
//
// Handshake: start is a level sampled on the rising edge. It is accepted only
// in IDLE with a non-zero ch_mask. busy is high for the whole run. done is a
// one-cycle pulse in the first idle cycle after a run ends or is stopped.
// A start sampled while done is high is accepted.
module demux_sel_sequencer #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  parameter int PASS_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [(1<<SEL_W)-1:0]   ch_mask,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic                    loop,
  input  logic                    stop,
  output logic [SEL_W-1:0]        sel,
  output logic                    sel_valid,
  output logic                    ch_strobe,
  output logic                    busy,
  output logic                    done,
  output logic [PASS_W-1:0]       pass_cnt
);

  localparam int NCH = 1 << SEL_W;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  logic [NCH-1:0]     mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q;
  logic [DWELL_W-1:0] cnt;

  logic [DWELL_W-1:0] dwell_eff;
  logic [SEL_W-1:0]   start_idx;
  logic [SEL_W-1:0]   low_idx;
  logic [SEL_W-1:0]   next_idx;
  logic               next_found;

  // Dwell of zero behaves as one cycle per channel.
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // Priority scans. The first channel comes from the live mask. The wrap
  // target and the next channel above sel come from the latched mask. Scanning
  // from the top down lets the lowest qualifying bit win.
  always_comb begin
    start_idx  = '0;
    low_idx    = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) start_idx = SEL_W'(i);
      if (mask_q[i])  low_idx   = SEL_W'(i);
      if (mask_q[i] && (SEL_W'(i) > sel)) begin
        next_idx   = SEL_W'(i);
        next_found = 1'b1;
      end
    end
  end

  // Sequencer FSM. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask_q    <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
      cnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      ch_strobe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_cnt  <= '0;
    end else begin
      ch_strobe <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (ch_mask != '0)) begin
            mask_q    <= ch_mask;
            dwell_q   <= dwell_eff;
            loop_q    <= loop;
            sel       <= start_idx;
            sel_valid <= 1'b1;
            ch_strobe <= 1'b1;
            busy      <= 1'b1;
            cnt       <= dwell_eff - DWELL_W'(1);
            state     <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            // An abort ends the run without counting it as a completed sweep.
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (next_found) begin
            sel       <= next_idx;
            ch_strobe <= 1'b1;
            cnt       <= dwell_q - DWELL_W'(1);
          end else if (loop_q) begin
            // Wrap to the lowest channel. It re-strobes even for a one-bit mask.
            pass_cnt  <= pass_cnt + PASS_W'(1);
            sel       <= low_idx;
            ch_strobe <= 1'b1;
            cnt       <= dwell_q - DWELL_W'(1);
          end else begin
            pass_cnt  <= pass_cnt + PASS_W'(1);
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
